// File: rtl/common_pkg.sv
// Shared fetch-path types: instruction words, addresses and the
// tag entries that follow SRAM reads through the arbiter.
package common_pkg;

   localparam int INSTR_L      = 32;
   localparam int INSTR_ADDR_L = 16;

   typedef logic [INSTR_ADDR_L-1:0] instr_addr_t;

   localparam int N_IMEM_REQ  = 4;
   localparam int IMEM_RD_LAT = 2;

   typedef logic [$clog2(N_IMEM_REQ)-1:0] imem_req_id_t;

   typedef struct packed {
      logic         vld;
      imem_req_id_t id;
      logic         kill;
   } imem_tag_t;

endpackage

// File: rtl/imem_tag_pipe.sv
// Tag shift register that travels alongside the SRAM read latency.
// A flush marks every entry of that requester as killed, tail included.
module imem_tag_pipe
   import common_pkg::*;
#(
   parameter int N_REQ  = N_IMEM_REQ,
   parameter int RD_LAT = IMEM_RD_LAT
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic [$bits(imem_req_id_t)-1:0] push_id,
   input  logic [N_REQ-1:0]                flush,
   output logic                            tail_vld,
   output logic [$bits(imem_req_id_t)-1:0] tail_id,
   output logic                            tail_kill
);

   function automatic imem_tag_t kill_by_id(imem_tag_t t,
                                            logic [N_REQ-1:0] f);
      imem_tag_t r;
      r      = t;
      r.kill = t.kill | (t.vld & f[t.id]);
      return r;
   endfunction

   imem_tag_t stage [RD_LAT];
   imem_tag_t head;
   imem_tag_t last;

   always_comb begin
      head.vld  = push;
      head.id   = push_id;
      head.kill = push & flush[push_id];
      last      = kill_by_id(stage[RD_LAT-1], flush);
   end

   assign tail_vld  = last.vld;
   assign tail_id   = last.id;
   assign tail_kill = last.kill;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < RD_LAT; s++)
            stage[s] <= '0;
      end else begin
         stage[0] <= head;
         for (int s = 1; s < RD_LAT; s++)
            stage[s] <= kill_by_id(stage[s-1], flush);
      end
   end

endmodule

// File: rtl/imem_rd_arbiter.sv
// Round-robin, burst-limited arbiter sharing one instruction SRAM port.
// Routes fixed-latency read data back to the requester that issued it.
module imem_rd_arbiter
   import common_pkg::*;
#(
   parameter int N_REQ     = N_IMEM_REQ,
   parameter int RD_LAT    = IMEM_RD_LAT,
   parameter int MAX_OUT   = 3,
   parameter int BURST_LEN = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_REQ-1:0]                    req_vld,
   input  logic [N_REQ-1:0][INSTR_ADDR_L-1:0]  req_addr,
   output logic [N_REQ-1:0]                    req_rdy,
   input  logic [N_REQ-1:0]                    flush,
   output logic [N_REQ-1:0]                    rsp_vld,
   output logic [INSTR_L-1:0]                  rsp_instr,
   output logic                                mem_rd_en,
   output logic [INSTR_ADDR_L-1:0]             mem_rd_addr,
   input  logic [INSTR_L-1:0]                  mem_rd_data
);

   localparam int IDW = $bits(imem_req_id_t);
   localparam int BW  = $clog2(BURST_LEN + 1);

   localparam logic [2:0]    MAX_C   = 3'(MAX_OUT);
   localparam logic [2:0]    CNT_ONE = 3'd1;
   localparam logic [BW-1:0] BURST_C = BW'(BURST_LEN);
   localparam logic [BW-1:0] B_ONE   = BW'(1);
   localparam imem_req_id_t  LAST_ID = imem_req_id_t'(N_REQ - 1);
   localparam imem_req_id_t  ID_ONE  = imem_req_id_t'(1);

   logic [2:0]       out_cnt [N_REQ];
   imem_req_id_t     owner;
   imem_req_id_t     rr_ptr;
   logic [BW-1:0]    burst_cnt;

   logic [N_REQ-1:0] elig;
   logic             keep;
   logic             grant;
   logic             found;
   imem_req_id_t     idx;
   imem_req_id_t     win_id;

   logic             tail_vld;
   logic [IDW-1:0]   tail_id;
   logic             tail_kill;
   logic [N_REQ-1:0] tail_hit;
   logic [N_REQ-1:0] rsp_next;

   // Owner keeps the port while eligible and under the burst limit.
   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         elig[i] = rst & req_vld[i] & ~flush[i]
                 & (out_cnt[i] < MAX_C);
      keep   = (burst_cnt != '0) & elig[owner]
             & (burst_cnt < BURST_C);
      grant  = |elig;
      win_id = owner;
      found  = keep;
      idx    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = imem_req_id_t'((int'(rr_ptr) + k) % N_REQ);
         if (!found && elig[idx]) begin
            win_id = idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         req_rdy[i] = grant & (win_id == imem_req_id_t'(i));
      mem_rd_en   = |(req_vld & req_rdy);
      mem_rd_addr = mem_rd_en ? req_addr[win_id] : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= '0;
         rr_ptr    <= '0;
         burst_cnt <= '0;
      end else if (grant) begin
         if (keep) begin
            burst_cnt <= burst_cnt + B_ONE;
         end else begin
            owner     <= win_id;
            burst_cnt <= B_ONE;
            rr_ptr    <= (win_id == LAST_ID) ? '0 : win_id + ID_ONE;
         end
      end else begin
         burst_cnt <= '0;
      end
   end

   imem_tag_pipe #(
      .N_REQ  (N_REQ),
      .RD_LAT (RD_LAT)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .push      (grant),
      .push_id   (win_id),
      .flush     (flush),
      .tail_vld  (tail_vld),
      .tail_id   (tail_id),
      .tail_kill (tail_kill)
   );

   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         tail_hit[i] = tail_vld & (tail_id == imem_req_id_t'(i));
      rsp_next = tail_hit & {N_REQ{~tail_kill}};
   end

   // Killed entries still release their outstanding slot.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_REQ; i++)
            out_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_rdy[i] && !tail_hit[i])
               out_cnt[i] <= out_cnt[i] + CNT_ONE;
            else if (!req_rdy[i] && tail_hit[i])
               out_cnt[i] <= out_cnt[i] - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_vld   <= '0;
         rsp_instr <= '0;
      end else begin
         rsp_vld <= rsp_next;
         if (|rsp_next)
            rsp_instr <= mem_rd_data;
      end
   end

endmodule

// File: tb/tb_imem_rd_arbiter.sv
// Bench for imem_rd_arbiter: three instances (MAX_OUT 3/7/1) driven in
// parallel and compared each cycle against a behavioural model.
module tb_imem_rd_arbiter;
   import common_pkg::*;

   localparam int N   = 4;
   localparam int LAT = 2;
   localparam int BL  = 4;
   localparam int NI  = 3;

   function automatic int max_out(int k);
      case (k)
         0:       return 3;
         1:       return 7;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] sram_word(logic [15:0] a);
      return {a ^ 16'hA5A5, a};
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [N-1:0]        vld;
   logic [N-1:0]        flush;
   logic [N-1:0][15:0]  addr;

   logic [N-1:0] rdy    [NI];
   logic [N-1:0] rvld   [NI];
   logic [31:0]  rinstr [NI];
   logic         en     [NI];
   logic [15:0]  maddr  [NI];
   logic [31:0]  mdata  [NI];

   imem_rd_arbiter #(.MAX_OUT(3)) u0 (
      .clk(clk), .rst(rst), .req_vld(vld), .req_addr(addr),
      .req_rdy(rdy[0]), .flush(flush), .rsp_vld(rvld[0]),
      .rsp_instr(rinstr[0]), .mem_rd_en(en[0]),
      .mem_rd_addr(maddr[0]), .mem_rd_data(mdata[0]));

   imem_rd_arbiter #(.MAX_OUT(7)) u1 (
      .clk(clk), .rst(rst), .req_vld(vld), .req_addr(addr),
      .req_rdy(rdy[1]), .flush(flush), .rsp_vld(rvld[1]),
      .rsp_instr(rinstr[1]), .mem_rd_en(en[1]),
      .mem_rd_addr(maddr[1]), .mem_rd_data(mdata[1]));

   imem_rd_arbiter #(.MAX_OUT(1)) u2 (
      .clk(clk), .rst(rst), .req_vld(vld), .req_addr(addr),
      .req_rdy(rdy[2]), .flush(flush), .rsp_vld(rvld[2]),
      .rsp_instr(rinstr[2]), .mem_rd_en(en[2]),
      .mem_rd_addr(maddr[2]), .mem_rd_data(mdata[2]));

   // SRAM: word for the address presented LAT cycles earlier
   logic [15:0] sa0 [NI];
   logic [15:0] sa1 [NI];
   always @(posedge clk)
      for (int k = 0; k < NI; k++) begin
         sa1[k] <= sa0[k];
         sa0[k] <= maddr[k];
      end
   always_comb
      for (int k = 0; k < NI; k++)
         mdata[k] = sram_word(sa1[k]);

   int checks;
   int failures;
   int cyc;

   // model: grant history by due cycle, plus arbitration state
   int          m_owner [NI];
   int          m_bcnt  [NI];
   int          m_rr    [NI];
   logic [31:0] m_last  [NI];
   bit          s_vld   [NI][8];
   int          s_id    [NI][8];
   logic [15:0] s_addr  [NI][8];
   bit          s_kill  [NI][8];

   logic [N-1:0] o_rdy   [NI];
   logic [N-1:0] o_rvld  [NI];
   logic [31:0]  o_instr [NI];
   logic         o_en    [NI];
   logic [15:0]  o_addr  [NI];

   task automatic model_cycle(int k);
      int           cnt [N];
      bit           el  [N];
      int           win;
      int           sl;
      int           ix;
      bit           keep;
      logic [N-1:0] e_rdy;
      logic [N-1:0] e_rvld;
      logic [15:0]  e_addr;
      logic         e_en;
      logic [31:0]  e_instr;
      e_rdy  = '0;
      e_rvld = '0;
      e_addr = '0;
      e_en   = 1'b0;
      win    = -1;
      keep   = 1'b0;
      if (!rst) begin
         m_owner[k] = 0;
         m_bcnt[k]  = 0;
         m_rr[k]    = 0;
         m_last[k]  = '0;
         for (int d = 0; d < 8; d++) s_vld[k][d] = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) cnt[i] = 0;
         for (int d = 1; d <= LAT; d++) begin
            sl = (cyc + d) % 8;
            if (s_vld[k][sl]) cnt[s_id[k][sl]]++;
         end
         for (int i = 0; i < N; i++)
            el[i] = vld[i] && !flush[i] && cnt[i] < max_out(k);
         keep = m_bcnt[k] > 0 && el[m_owner[k]] && m_bcnt[k] < BL;
         if (keep) win = m_owner[k];
         else
            for (int j = 0; j < N; j++) begin
               ix = (m_rr[k] + j) % N;
               if (win < 0 && el[ix]) win = ix;
            end
         if (win >= 0) begin
            e_rdy[win] = 1'b1;
            e_en       = 1'b1;
            e_addr     = addr[win];
         end
         sl = cyc % 8;
         if (s_vld[k][sl] && !s_kill[k][sl]) begin
            e_rvld[s_id[k][sl]] = 1'b1;
            m_last[k] = sram_word(s_addr[k][sl]);
         end
         s_vld[k][sl] = 1'b0;
         for (int d = 1; d <= LAT; d++) begin
            sl = (cyc + d) % 8;
            if (s_vld[k][sl] && flush[s_id[k][sl]]) s_kill[k][sl] = 1'b1;
         end
         if (win >= 0) begin
            sl = (cyc + LAT + 1) % 8;
            s_vld[k][sl]  = 1'b1;
            s_id[k][sl]   = win;
            s_addr[k][sl] = addr[win];
            s_kill[k][sl] = flush[win];
            if (keep) m_bcnt[k]++;
            else begin
               m_owner[k] = win;
               m_bcnt[k]  = 1;
               m_rr[k]    = (win + 1) % N;
            end
         end else begin
            m_bcnt[k] = 0;
         end
      end
      e_instr = m_last[k];
      checks += 5;
      if (o_rdy[k] !== e_rdy) begin
         failures++;
         $display("FAIL req_rdy inst=%0d cyc=%0d got=%b want=%b",
                  k, cyc, o_rdy[k], e_rdy);
      end
      if (o_en[k] !== e_en) begin
         failures++;
         $display("FAIL mem_rd_en inst=%0d cyc=%0d got=%b want=%b",
                  k, cyc, o_en[k], e_en);
      end
      if (o_addr[k] !== e_addr) begin
         failures++;
         $display("FAIL mem_rd_addr inst=%0d cyc=%0d got=%h want=%h",
                  k, cyc, o_addr[k], e_addr);
      end
      if (o_rvld[k] !== e_rvld) begin
         failures++;
         $display("FAIL rsp_vld inst=%0d cyc=%0d got=%b want=%b",
                  k, cyc, o_rvld[k], e_rvld);
      end
      if (o_instr[k] !== e_instr) begin
         failures++;
         $display("FAIL rsp_instr inst=%0d cyc=%0d got=%h want=%h",
                  k, cyc, o_instr[k], e_instr);
      end
   endtask

   // inputs change at posedge+1; outputs sampled at negedge
   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         o_rdy[k]   = rdy[k];
         o_rvld[k]  = rvld[k];
         o_instr[k] = rinstr[k];
         o_en[k]    = en[k];
         o_addr[k]  = maddr[k];
         model_cycle(k);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst   = 1'b0;
      vld   = '0;
      flush = '0;
      tick();
      rst = 1'b1;
   endtask

   task automatic rand_addr();
      for (int i = 0; i < N; i++) addr[i] = 16'($urandom);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      vld = '1;
      rand_addr();
      tick();
      for (int k = 0; k < NI; k++) begin
         checks++;
         if ({o_rdy[k], o_en[k], o_addr[k], o_rvld[k], o_instr[k]} !== '0) begin
            failures++;
            $display("FAIL reset_outputs inst=%0d got=%b/%b/%h/%b/%h want=0",
                     k, o_rdy[k], o_en[k], o_addr[k], o_rvld[k], o_instr[k]);
         end
      end
      vld = '0;
      rst = 1'b1;
   endtask

   task automatic test_single();
      logic [31:0] w;
      apply_reset();
      tick();
      vld     = 4'b0001;
      addr[0] = 16'h0010;
      tick();
      checks += 2;
      if (o_rdy[0] !== 4'b0001 || o_en[0] !== 1'b1) begin
         failures++;
         $display("FAIL single_grant got=%b/%b want=0001/1", o_rdy[0], o_en[0]);
      end
      if (o_addr[0] !== 16'h0010) begin
         failures++;
         $display("FAIL single_addr got=%h want=0010", o_addr[0]);
      end
      vld = '0;
      tick();
      tick();
      tick();
      w = sram_word(16'h0010);
      checks += 2;
      if (o_rvld[0] !== 4'b0001) begin
         failures++;
         $display("FAIL single_rsp_vld got=%b want=0001", o_rvld[0]);
      end
      if (o_instr[0] !== w) begin
         failures++;
         $display("FAIL single_rsp_instr got=%h want=%h", o_instr[0], w);
      end
   endtask

   task automatic test_burst();
      logic [N-1:0] exp;
      apply_reset();
      vld = '1;
      for (int c = 0; c < 20; c++) begin
         rand_addr();
         tick();
         exp = 4'b0001 << ((c / BL) % N);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_rdy[k] !== exp) begin
               failures++;
               $display("FAIL burst_order inst=%0d c=%0d got=%b want=%b",
                        k, c, o_rdy[k], exp);
            end
         end
      end
      vld = '0;
   endtask

   task automatic test_single_limit();
      logic [N-1:0] exp;
      apply_reset();
      vld = 4'b0100;
      for (int c = 0; c < 9; c++) begin
         rand_addr();
         tick();
         checks += 2;
         if (o_rdy[0] !== 4'b0100) begin
            failures++;
            $display("FAIL limit3 c=%0d got=%b want=0100", c, o_rdy[0]);
         end
         exp = (c % 3 == 0) ? 4'b0100 : 4'b0000;
         if (o_rdy[2] !== exp) begin
            failures++;
            $display("FAIL limit1 c=%0d got=%b want=%b", c, o_rdy[2], exp);
         end
      end
      vld = '0;
   endtask

   task automatic test_flush();
      apply_reset();
      vld = 4'b0010;
      rand_addr();
      tick();
      rand_addr();
      tick();
      vld   = '0;
      flush = 4'b0010;
      checks++;
      if (u0.out_cnt[1] !== 3'd2) begin
         failures++;
         $display("FAIL flush_cnt_before got=%0d want=2", u0.out_cnt[1]);
      end
      tick();
      flush = '0;
      for (int c = 3; c < 6; c++) begin
         if (c == 4) begin
            checks++;
            if (u0.out_cnt[1] !== 3'd0) begin
               failures++;
               $display("FAIL flush_cnt_after got=%0d want=0", u0.out_cnt[1]);
            end
         end
         tick();
         checks++;
         if (o_rvld[0][1] !== 1'b0 || o_rvld[1][1] !== 1'b0) begin
            failures++;
            $display("FAIL flush_rsp c=%0d got=%b/%b want=0",
                     c, o_rvld[0][1], o_rvld[1][1]);
         end
      end
      vld = 4'b0010;
      rand_addr();
      tick();
      vld = '0;
      tick();
      tick();
      tick();
      checks++;
      if (o_rvld[0] !== 4'b0010) begin
         failures++;
         $display("FAIL flush_regrant_rsp got=%b want=0010", o_rvld[0]);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      vld = '1;
      for (int c = 0; c < 3; c++) begin
         rand_addr();
         tick();
      end
      rst = 1'b0;
      tick();
      for (int k = 0; k < NI; k++) begin
         checks++;
         if ({o_rdy[k], o_en[k], o_addr[k], o_rvld[k], o_instr[k]} !== '0) begin
            failures++;
            $display("FAIL midreset_outputs inst=%0d got=%b/%b/%h/%b/%h want=0",
                     k, o_rdy[k], o_en[k], o_addr[k], o_rvld[k], o_instr[k]);
         end
      end
      rst = 1'b1;
      vld = '0;
      for (int c = 0; c < 5; c++) begin
         tick();
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (o_rvld[k] !== '0) begin
               failures++;
               $display("FAIL midreset_stale inst=%0d c=%0d got=%b want=0000",
                        k, c, o_rvld[k]);
            end
         end
      end
   endtask

   task automatic test_burst_break();
      logic [N-1:0] exp;
      apply_reset();
      vld = 4'b1001;
      for (int c = 0; c < 6; c++) begin
         rand_addr();
         tick();
         exp = (c < BL) ? 4'b0001 : 4'b1000;
         checks++;
         if (o_rdy[0] !== exp) begin
            failures++;
            $display("FAIL break_pre c=%0d got=%b want=%b", c, o_rdy[0], exp);
         end
      end
      vld = 4'b0001;
      rand_addr();
      tick();
      checks += 2;
      if (o_rdy[0] !== 4'b0001) begin
         failures++;
         $display("FAIL break_grant got=%b want=0001", o_rdy[0]);
      end
      if (u0.burst_cnt !== 3'd1) begin
         failures++;
         $display("FAIL break_burst_cnt got=%0d want=1", u0.burst_cnt);
      end
      vld = '0;
      tick();
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 600; c++) begin
         vld   = 4'($urandom);
         flush = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         rst   = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
         rand_addr();
         tick();
      end
      rst   = 1'b1;
      vld   = '0;
      flush = '0;
      for (int c = 0; c < 5; c++) tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst      = 1'b0;
      vld      = '0;
      flush    = '0;
      addr     = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_single();
      test_burst();
      test_single_limit();
      test_flush();
      test_reset_mid();
      test_burst_break();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
